// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: run-time loadable instruction memory with a registered
// valid/ready fetch port (one-cycle latency, one-entry response buffer).
module imem_fetch_unit #(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 64,
   parameter int                ADDR_W   = 8,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic              load_last,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_done,
   output logic [ADDR_W:0]   prog_len,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              busy_load
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wp_q, wp_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic              load_done_q, load_done_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;
   logic              mem_we;
   logic              in_range;
   logic              wp_last;
   logic [DATA_W-1:0] mem [DEPTH];

   // prog_len never exceeds DEPTH, so in_range also guarantees a legal array index
   assign in_range = {1'b0, fetch_addr} < prog_len_q;
   assign wp_last  = wp_q == IDX_W'(DEPTH - 1);

   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      prog_len_d   = prog_len_q;
      load_done_d  = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      mem_we       = 1'b0;
      fetch_ready  = (state_q == RUN) && !load_start && (!resp_valid_q || resp_ready);
      if (load_start) begin
         state_d      = LOAD;
         wp_d         = '0;
         resp_valid_d = 1'b0;
      end else if (state_q == LOAD) begin
         if (load_valid) begin
            mem_we = 1'b1;
            wp_d   = wp_q + IDX_W'(1);
            if (load_last || wp_last) begin
               state_d     = RUN;
               prog_len_d  = (ADDR_W + 1)'(wp_q) + (ADDR_W + 1)'(1);
               load_done_d = 1'b1;
            end
         end
      end else if (state_q == RUN) begin
         if (fetch_req && fetch_ready) begin
            resp_valid_d = 1'b1;
            resp_data_d  = in_range ? mem[fetch_addr[IDX_W-1:0]] : NOP_WORD;
            resp_err_d   = !in_range;
         end else if (resp_ready) begin
            resp_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         wp_q         <= '0;
         prog_len_q   <= '0;
         load_done_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wp_q         <= wp_d;
         prog_len_q   <= prog_len_d;
         load_done_q  <= load_done_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wp_q] <= load_data;
   end

   assign load_done  = load_done_q;
   assign prog_len   = prog_len_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign busy_load  = state_q == LOAD;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed scenario tests for imem_fetch_unit with
// hand-derived expected words, prog_len values and handshake behaviour.
module tb_imem_fetch_unit;
   logic        clk;
   logic        rstn;
   logic        load_start;
   logic        load_valid;
   logic        load_last;
   logic [31:0] load_data;
   logic        load_done;
   logic [8:0]  prog_len;
   logic        fetch_req;
   logic [7:0]  fetch_addr;
   logic        fetch_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        busy_load;
   int          checks;
   int          errors;

   imem_fetch_unit dut (
      .clk(clk), .rstn(rstn),
      .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
      .load_data(load_data), .load_done(load_done), .prog_len(prog_len),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_err(resp_err), .busy_load(busy_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wa(input int i);
      return 32'hA5A5_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] wb(input int i);
      return 32'h0BAD_0000 + 32'(i * 256);
   endfunction

   function automatic logic [31:0] wr(input int i);
      return 32'h1234_0000 + 32'(i);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({load_done, prog_len, fetch_ready, resp_valid, resp_data, resp_err, busy_load} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got done=%b len=%0d rdy=%b rv=%b data=%h err=%b busy=%b, want all 0",
                  load_done, prog_len, fetch_ready, resp_valid, resp_data, resp_err, busy_load);
      end
      step();
      rstn = 1'b1;
      fetch_req = 1'b1;
      fetch_addr = 8'd0;
      #1;
      checks++;
      if (fetch_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_fetch_ready: got %b want 0", fetch_ready);
      end
      step();
      fetch_req = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || prog_len !== 9'd0 || busy_load !== 1'b0) begin
         errors++;
         $display("FAIL idle_state: got rv=%b len=%0d busy=%b want 0 0 0", resp_valid, prog_len, busy_load);
      end
   endtask

   task automatic test_load14();
      int pulses;
      pulses = 0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      checks++;
      if (busy_load !== 1'b1) begin
         errors++;
         $display("FAIL load_busy: got %b want 1", busy_load);
      end
      for (int i = 0; i < 14; i++) begin
         load_valid = 1'b1;
         load_data = wa(i);
         load_last = (i == 13);
         step();
         pulses += int'(load_done);
      end
      load_valid = 1'b0;
      load_last = 1'b0;
      checks++;
      if (load_done !== 1'b1 || prog_len !== 9'd14 || busy_load !== 1'b0) begin
         errors++;
         $display("FAIL load14_done: got done=%b len=%0d busy=%b want 1 14 0", load_done, prog_len, busy_load);
      end
      step();
      pulses += int'(load_done);
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL load14_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_stream();
      resp_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         fetch_req = 1'b1;
         fetch_addr = 8'(i);
         #1;
         checks++;
         if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready[%0d]: got %b want 1", i, fetch_ready);
         end
         step();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== wa(i) || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL stream_resp[%0d]: got rv=%b data=%h err=%b want 1 %h 0", i, resp_valid, resp_data, resp_err, wa(i));
         end
      end
      fetch_req = 1'b0;
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: got rv=%b want 0", resp_valid);
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0]  addrs [3];
      logic [31:0] exp_d [3];
      logic        exp_e [3];
      addrs = '{8'd13, 8'd14, 8'd200};
      exp_d = '{wa(13), 32'h0000_0000, 32'h0000_0000};
      exp_e = '{1'b0, 1'b1, 1'b1};
      resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fetch_req = 1'b1;
         fetch_addr = addrs[k];
         step();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== exp_d[k] || resp_err !== exp_e[k]) begin
            errors++;
            $display("FAIL oor_addr%0d: got rv=%b data=%h err=%b want 1 %h %b",
                     addrs[k], resp_valid, resp_data, resp_err, exp_d[k], exp_e[k]);
         end
      end
      fetch_req = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      resp_ready = 1'b1;
      fetch_req = 1'b1;
      fetch_addr = 8'd2;
      step();
      resp_ready = 1'b0;
      fetch_addr = 8'd5;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b want 0", c, fetch_ready);
         end
         step();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== wa(2) || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rv=%b data=%h err=%b want 1 %h 0", c, resp_valid, resp_data, resp_err, wa(2));
         end
      end
      resp_ready = 1'b1;
      #1;
      checks++;
      if (fetch_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 1", fetch_ready);
      end
      step();
      fetch_req = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== wa(5)) begin
         errors++;
         $display("FAIL bp_release_resp: got rv=%b data=%h want 1 %h", resp_valid, resp_data, wa(5));
      end
      step();
   endtask

   task automatic test_flush_restart();
      resp_ready = 1'b0;
      fetch_req = 1'b1;
      fetch_addr = 8'd7;
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== wa(7)) begin
         errors++;
         $display("FAIL flush_pre: got rv=%b data=%h want 1 %h", resp_valid, resp_data, wa(7));
      end
      fetch_addr = 8'd8;
      load_start = 1'b1;
      #1;
      checks++;
      if (fetch_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready: got %b want 0", fetch_ready);
      end
      step();
      load_start = 1'b0;
      fetch_req = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || busy_load !== 1'b1) begin
         errors++;
         $display("FAIL flush_resp: got rv=%b busy=%b want 0 1", resp_valid, busy_load);
      end
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data = wb(i);
         step();
      end
      // restart while a word is offered: that word must be dropped
      load_start = 1'b1;
      load_data = 32'hDEAD_BEEF;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_data = wr(i);
         load_last = (i == 1);
         step();
      end
      load_valid = 1'b0;
      load_last = 1'b0;
      checks++;
      if (prog_len !== 9'd2 || load_done !== 1'b1 || busy_load !== 1'b0) begin
         errors++;
         $display("FAIL restart_len: got len=%0d done=%b busy=%b want 2 1 0", prog_len, load_done, busy_load);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_req = 1'b1;
         fetch_addr = 8'(i);
         step();
         checks++;
         if (resp_data !== (i < 2 ? wr(i) : 32'h0) || resp_err !== (i >= 2)) begin
            errors++;
            $display("FAIL restart_fetch[%0d]: got data=%h err=%b want %h %b",
                     i, resp_data, resp_err, (i < 2 ? wr(i) : 32'h0), (i >= 2));
         end
      end
      fetch_req = 1'b0;
      step();
   endtask

   task automatic test_full_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         load_valid = 1'b1;
         load_last = 1'b0;
         load_data = wb(i);
         step();
         if (i == 62) begin
            checks++;
            if (busy_load !== 1'b1) begin
               errors++;
               $display("FAIL full_early_exit: got busy=%b want 1", busy_load);
            end
         end
      end
      checks++;
      if (busy_load !== 1'b0 || prog_len !== 9'd64 || load_done !== 1'b1) begin
         errors++;
         $display("FAIL full_exit: got busy=%b len=%0d done=%b want 0 64 1", busy_load, prog_len, load_done);
      end
      load_data = 32'hFFFF_FFFF;
      step();
      load_valid = 1'b0;
      checks++;
      if (prog_len !== 9'd64 || busy_load !== 1'b0 || load_done !== 1'b0) begin
         errors++;
         $display("FAIL full_overflow: got len=%0d busy=%b done=%b want 64 0 0", prog_len, busy_load, load_done);
      end
      resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fetch_req = 1'b1;
         fetch_addr = (k == 0) ? 8'd63 : (k == 1) ? 8'd64 : 8'd0;
         step();
         checks++;
         if (resp_data !== ((k == 0) ? wb(63) : (k == 1) ? 32'h0 : wb(0)) || resp_err !== (k == 1)) begin
            errors++;
            $display("FAIL full_fetch[%0d]: got data=%h err=%b want %h %b", k, resp_data, resp_err,
                     ((k == 0) ? wb(63) : (k == 1) ? 32'h0 : wb(0)), (k == 1));
         end
      end
      fetch_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data = wr(i + 10);
         step();
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({load_done, prog_len, fetch_ready, resp_valid, resp_data, resp_err, busy_load} !== '0) begin
         errors++;
         $display("FAIL midload_reset: got done=%b len=%0d rdy=%b rv=%b data=%h err=%b busy=%b, want all 0",
                  load_done, prog_len, fetch_ready, resp_valid, resp_data, resp_err, busy_load);
      end
      load_valid = 1'b0;
      step();
      rstn = 1'b1;
      fetch_req = 1'b1;
      fetch_addr = 8'd0;
      #1;
      checks++;
      if (fetch_ready !== 1'b0) begin
         errors++;
         $display("FAIL midload_idle_ready: got %b want 0", fetch_ready);
      end
      step();
      fetch_req = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || prog_len !== 9'd0 || busy_load !== 1'b0) begin
         errors++;
         $display("FAIL midload_idle: got rv=%b len=%0d busy=%b want 0 0 0", resp_valid, prog_len, busy_load);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last = 1'b0;
      load_data = '0;
      fetch_req = 1'b0;
      fetch_addr = '0;
      resp_ready = 1'b0;
      test_reset();
      test_load14();
      test_stream();
      test_out_of_range();
      test_backpressure();
      test_flush_restart();
      test_full_load();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised, loadable instruction memory with a registered fetch port; successor to the fixed 14-word combinational instruction ROM.
- The program is streamed in through a load port at run time, not hard-coded.
- Fetches use a valid/ready request/response handshake with one cycle of read latency and a one-entry output buffer.
- Sits between the program loader/testbench and the processor fetch stage.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of instruction words; must be at least 2 and at most 2**ADDR_W.
- ADDR_W, 8, width of the word-address program counter.
- NOP_WORD, 32'h0000_0000, word returned for out-of-range fetches (sll $0,$0,0).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that begins a program load at word 0.
- load_valid  in  1  load_data is valid this cycle.
- load_last  in  1  qualifies load_valid: this is the final program word.
- load_data  in  DATA_W  program word to write.
- load_done  out  1  single-cycle pulse when a load completes.
- prog_len  out  ADDR_W+1  number of words loaded by the last completed load (0..DEPTH).
- fetch_req  in  1  fetch request valid.
- fetch_addr  in  ADDR_W  word address (PC) to fetch.
- fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready.
- resp_valid  out  1  resp_data/resp_err are valid.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_data  out  DATA_W  fetched instruction.
- resp_err  out  1  fetch_addr was at or beyond prog_len; resp_data = NOP_WORD.
- busy_load  out  1  high while in LOAD.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; write pointer wp=0; prog_len=0.
  - load_done=0, resp_valid=0, resp_data=0, resp_err=0, busy_load=0.
  - Memory array is not cleared.
- States:
  - IDLE: no program loaded; fetch_ready=0; load_start goes to LOAD.
  - LOAD: busy_load=1; fetch_ready=0.
    - Each cycle with load_valid: mem[wp] <= load_data; wp <= wp+1.
    - Exit to RUN when load_valid && (load_last || wp==DEPTH-1). That cycle's word is written; prog_len <= wp+1; load_done pulses on the next cycle.
    - load_start inside LOAD restarts: wp=0; no write that cycle even if load_valid.
  - RUN: serves fetches. load_start goes to LOAD with wp=0 and flushes resp_valid to 0 in the same edge; a fetch requested in that cycle is not accepted.
- Fetch handshake:
  - fetch_ready = (state==RUN) && !load_start && (!resp_valid || resp_ready).
  - On acceptance at edge N, resp_valid=1 at N+1: resp_data=mem[fetch_addr] and resp_err=0 if fetch_addr<prog_len, else NOP_WORD and resp_err=1.
  - Back-to-back accepts with resp_ready held high give one response per cycle.
  - With resp_ready=0, resp_valid/resp_data/resp_err hold stable and fetch_ready=0.
  - resp_valid clears when resp_ready=1 and no new fetch is accepted that cycle.
- Width rules:
  - prog_len compare is unsigned at ADDR_W+1 bits.
  - fetch_addr >= DEPTH is always out of range and never indexes the array.
- Overflow: load_valid after the word at DEPTH-1 is impossible (the block is already in RUN); load_valid in IDLE or RUN is ignored.
- Empty load: a load cannot complete with zero words, so prog_len is 0 only after reset.
- Reset mid-load: prog_len=0 and state=IDLE; partially written words remain in the array but are unreachable (resp_err=1).

Test Plan:
- Reset, then fetch_req with addr 0 -> fetch_ready=0 in IDLE; resp_valid stays 0; prog_len=0.
- Load 14 words, the 14th with load_last; fetch addr 0..13 back-to-back with resp_ready=1 -> one response per cycle, resp_data equal to loaded words with 1-cycle latency; load_done pulses once; prog_len=14.
- Fetch addr 14 and addr 200 after the 14-word load -> resp_data=0x00000000, resp_err=1.
- Hold resp_ready=0 for 3 cycles with fetch_req high -> response held stable, fetch_ready=0, no requests lost; release -> next address served the following cycle.
- Stream 64 words with load_last=0 -> auto-exit to RUN after word 63, prog_len=64; fetch 63 returns the last word.
- Assert load_start while resp_valid=1 -> resp_valid flushed; assert rstn=0 mid-load after 5 words -> state IDLE, prog_len=0, all outputs 0.
